// File: rtl/branch_ctrl_pkg.sv
// Shared constants for the branch/flush controller: opcodes, PC mux selects,
// FSM state encoding and the opcode-to-select decode helper.
package branch_ctrl_pkg;

   localparam logic [6:0] OP_BEQ  = 7'h10;
   localparam logic [6:0] OP_BNE  = 7'h11;
   localparam logic [6:0] OP_BLT  = 7'h12;
   localparam logic [6:0] OP_BLTU = 7'h13;
   localparam logic [6:0] OP_JMP  = 7'h20;
   localparam logic [6:0] OP_JR   = 7'h21;
   localparam logic [6:0] OP_ERET = 7'h30;

   localparam logic [2:0] PC_SRC_SEQ    = 3'd0;
   localparam logic [2:0] PC_SRC_BRANCH = 3'd1;
   localparam logic [2:0] PC_SRC_JUMP   = 3'd2;
   localparam logic [2:0] PC_SRC_REG    = 3'd3;
   localparam logic [2:0] PC_SRC_TRAP   = 3'd4;
   localparam logic [2:0] PC_SRC_ERET   = 3'd5;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_FLUSH = 1'b1
   } state_t;

   // Select for a decode-stage opcode, given the compare result for branches.
   function automatic logic [2:0] decode_sel(input logic [6:0] op, input logic taken);
      logic [2:0] sel;
      sel = PC_SRC_SEQ;
      case (op)
         OP_BEQ, OP_BNE, OP_BLT, OP_BLTU: sel = taken ? PC_SRC_BRANCH : PC_SRC_SEQ;
         OP_JMP:  sel = PC_SRC_JUMP;
         OP_JR:   sel = PC_SRC_REG;
         OP_ERET: sel = PC_SRC_ERET;
         default: sel = PC_SRC_SEQ;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/branch_ctrl_cmp.sv
// Combinational branch condition evaluator: full-width equality, signed and
// unsigned less-than, selected by the decode-stage opcode.
module branch_cmp
   import branch_ctrl_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [6:0]      opcode,
   input  logic [XLEN-1:0] rs1_val,
   input  logic [XLEN-1:0] rs2_val,
   output logic            taken
);

   always_comb begin
      taken = 1'b0;
      case (opcode)
         OP_BEQ:  taken = (rs1_val == rs2_val);
         OP_BNE:  taken = (rs1_val != rs2_val);
         OP_BLT:  taken = ($signed(rs1_val) < $signed(rs2_val));
         OP_BLTU: taken = (rs1_val < rs2_val);
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_ctrl.sv
// Registered next-PC source selector with a programmable post-redirect flush
// window and a wrapping count of taken redirects.
module branch_ctrl
   import branch_ctrl_pkg::*;
#(
   parameter int XLEN         = 32,
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             stall,
   input  logic [6:0]       opcode,
   input  logic [XLEN-1:0]  rs1_val,
   input  logic [XLEN-1:0]  rs2_val,
   input  logic             trap_req,
   output logic [2:0]       pc_src,
   output logic             redirect,
   output logic             flush,
   output logic [CNT_W-1:0] redirect_cnt
);

   localparam int FCNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [FCNT_W-1:0] FCNT_LOAD = FCNT_W'(FLUSH_CYCLES - 1);
   // With a single-cycle flush there is no wrong-path window to sit in.
   localparam state_t REDIRECT_STATE = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_IDLE;

   state_t             state_reg, state_next;
   logic [FCNT_W-1:0]  fcnt_reg, fcnt_next;
   logic [2:0]         pc_src_reg, pc_src_next;
   logic               redirect_reg, redirect_next;
   logic               flush_reg, flush_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   logic               taken;
   logic [2:0]         sel;

   branch_cmp #(
      .XLEN (XLEN)
   ) u_cmp (
      .opcode  (opcode),
      .rs1_val (rs1_val),
      .rs2_val (rs2_val),
      .taken   (taken)
   );

   always_comb begin
      state_next    = state_reg;
      fcnt_next     = fcnt_reg;
      pc_src_next   = pc_src_reg;
      redirect_next = redirect_reg;
      flush_next    = flush_reg;
      cnt_next      = cnt_reg;
      sel           = PC_SRC_SEQ;

      if (!stall) begin
         // Traps are accepted even inside the flush window; opcodes are not.
         if (trap_req) begin
            sel = PC_SRC_TRAP;
         end else if (state_reg == ST_IDLE) begin
            sel = decode_sel(opcode, taken);
         end

         if (sel != PC_SRC_SEQ) begin
            pc_src_next   = sel;
            redirect_next = 1'b1;
            flush_next    = 1'b1;
            fcnt_next     = FCNT_LOAD;
            state_next    = REDIRECT_STATE;
            cnt_next      = cnt_reg + CNT_W'(1);
         end else begin
            pc_src_next   = PC_SRC_SEQ;
            redirect_next = 1'b0;
            flush_next    = 1'b0;
            if (state_reg == ST_FLUSH) begin
               if (fcnt_reg == '0) begin
                  state_next = ST_IDLE;
               end else begin
                  fcnt_next  = fcnt_reg - FCNT_W'(1);
                  flush_next = 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg    <= ST_IDLE;
         fcnt_reg     <= '0;
         pc_src_reg   <= PC_SRC_SEQ;
         redirect_reg <= 1'b0;
         flush_reg    <= 1'b0;
         cnt_reg      <= '0;
      end else begin
         state_reg    <= state_next;
         fcnt_reg     <= fcnt_next;
         pc_src_reg   <= pc_src_next;
         redirect_reg <= redirect_next;
         flush_reg    <= flush_next;
         cnt_reg      <= cnt_next;
      end
   end

   assign pc_src       = pc_src_reg;
   assign redirect     = redirect_reg;
   assign flush        = flush_reg;
   assign redirect_cnt = cnt_reg;

endmodule

// File: tb/tb_branch_ctrl.sv
// Scoreboard bench for branch_ctrl: stimulus pushes the reference model's
// expected outputs per edge, an independent monitor pops and compares them.
module tb_branch_ctrl;
   import branch_ctrl_pkg::*;

   localparam int XLEN = 32;
   localparam int FC   = 3;
   localparam int CW   = 4;
   localparam logic [6:0] OP_ADD = 7'h33;

   logic            clock = 1'b0;
   logic            reset, stall, trap_req;
   logic [6:0]      opcode;
   logic [XLEN-1:0] rs1_val, rs2_val;
   logic [2:0]      pc_src;
   logic            redirect, flush;
   logic [CW-1:0]   redirect_cnt;

   branch_ctrl #(
      .XLEN         (XLEN),
      .FLUSH_CYCLES (FC),
      .CNT_W        (CW)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .stall        (stall),
      .opcode       (opcode),
      .rs1_val      (rs1_val),
      .rs2_val      (rs2_val),
      .trap_req     (trap_req),
      .pc_src       (pc_src),
      .redirect     (redirect),
      .flush        (flush),
      .redirect_cnt (redirect_cnt)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [2:0] pc;
      logic       redir;
      logic       fl;
      int         cnt;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   txn    = 0;

   // Reference model: outputs plus the number of flush cycles still owed.
   logic [2:0] m_pc = 3'd0;
   logic       m_redir = 1'b0;
   logic       m_fl = 1'b0;
   int         m_cnt = 0;
   int         m_left = 0;

   function automatic logic [2:0] ref_sel(input logic [6:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
      case (op)
         OP_BEQ:  return (a == b) ? 3'd1 : 3'd0;
         OP_BNE:  return (a != b) ? 3'd1 : 3'd0;
         OP_BLT:  return (int'(a) < int'(b)) ? 3'd1 : 3'd0;
         OP_BLTU: return (a < b) ? 3'd1 : 3'd0;
         OP_JMP:  return 3'd2;
         OP_JR:   return 3'd3;
         OP_ERET: return 3'd5;
         default: return 3'd0;
      endcase
   endfunction

   task automatic step(input bit rst, input bit st, input logic [6:0] op,
                       input logic [31:0] a, input logic [31:0] b, input bit tr);
      logic [2:0] s;
      reset = rst; stall = st; opcode = op; rs1_val = a; rs2_val = b; trap_req = tr;
      @(posedge clock);
      if (rst) begin
         m_pc = 3'd0; m_redir = 1'b0; m_fl = 1'b0; m_cnt = 0; m_left = 0;
      end else if (!st) begin
         if (tr) s = 3'd4;
         else if (m_fl && FC > 1) s = 3'd0;
         else s = ref_sel(op, a, b);
         if (s != 3'd0) begin
            m_pc = s; m_redir = 1'b1; m_fl = 1'b1; m_left = FC - 1;
            m_cnt = (m_cnt + 1) % (1 << CW);
         end else begin
            m_pc = 3'd0; m_redir = 1'b0;
            if (m_left > 0) begin m_left--; m_fl = 1'b1; end
            else m_fl = 1'b0;
         end
      end
      q.push_back('{m_pc, m_redir, m_fl, m_cnt});
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, OP_ADD, 32'd0, 32'd0, 0);
   endtask

   function automatic logic [31:0] pick_val();
      case ($urandom_range(0, 6))
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'd5;
         3: return 32'hFFFF_FFFF;
         4: return 32'h8000_0000;
         5: return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   function automatic logic [6:0] pick_op();
      case ($urandom_range(0, 8))
         0: return OP_BEQ;
         1: return OP_BNE;
         2: return OP_BLT;
         3: return OP_BLTU;
         4: return OP_JMP;
         5: return OP_JR;
         6: return OP_ERET;
         7: return OP_ADD;
         default: return 7'($urandom);
      endcase
   endfunction

   // Monitor: one expected record per clock edge, compared mid-cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (q.size() > 0) begin
            e = q.pop_front();
            txn++;
            checks += 4;
            if (pc_src !== e.pc) begin
               errors++;
               $display("FAIL pc_src txn=%0d got=%0d expected=%0d", txn, pc_src, e.pc);
            end
            if (redirect !== e.redir) begin
               errors++;
               $display("FAIL redirect txn=%0d got=%0b expected=%0b", txn, redirect, e.redir);
            end
            if (flush !== e.fl) begin
               errors++;
               $display("FAIL flush txn=%0d got=%0b expected=%0b", txn, flush, e.fl);
            end
            if (redirect_cnt !== CW'(e.cnt)) begin
               errors++;
               $display("FAIL redirect_cnt txn=%0d got=%0d expected=%0d", txn, redirect_cnt,
                        e.cnt);
            end
            if (txn <= 120)
               $display("txn %0d: pc_src=%0d redirect=%0b flush=%0b cnt=%0d", txn, pc_src,
                        redirect, flush, redirect_cnt);
         end
      end
   end

   initial begin
      step(1, 0, OP_ADD, 32'd0, 32'd0, 0);
      step(1, 0, OP_ADD, 32'd0, 32'd0, 0);

      // Reset in the middle of a flush window
      step(0, 0, OP_BEQ, 32'd5, 32'd5, 0);
      step(1, 0, OP_JMP, 32'd0, 32'd0, 0);
      step(0, 0, OP_ADD, 32'd1, 32'd2, 0);
      idle(2);

      // Compare matrix
      step(0, 0, OP_BLT, 32'hFFFF_FFFF, 32'd1, 0);
      idle(3);
      step(0, 0, OP_BLTU, 32'hFFFF_FFFF, 32'd1, 0);
      step(0, 0, OP_BNE, 32'd3, 32'd3, 0);
      step(0, 0, OP_BEQ, 32'd7, 32'd7, 0);
      idle(3);

      // Back-to-back JMP then JR: JR falls in the flush window
      step(0, 0, OP_JMP, 32'd0, 32'd0, 0);
      step(0, 0, OP_JR, 32'd0, 32'd0, 0);
      idle(4);

      // Trap wins over JMP; trap in 2nd flush cycle restarts the window
      step(0, 0, OP_JMP, 32'd0, 32'd0, 1);
      step(0, 0, OP_ADD, 32'd0, 32'd0, 0);
      step(0, 0, OP_ADD, 32'd0, 32'd0, 1);
      idle(4);

      // Stall for 4 cycles inside a flush window, with a live JMP presented
      step(0, 0, OP_JR, 32'd0, 32'd0, 0);
      step(0, 0, OP_ADD, 32'd0, 32'd0, 0);
      for (int i = 0; i < 4; i++) step(0, 1, OP_JMP, 32'd0, 32'd0, 0);
      idle(4);

      // Counter wrap: 17 ERETs with a 4-bit counter
      step(1, 0, OP_ADD, 32'd0, 32'd0, 0);
      for (int i = 0; i < 17; i++) begin
         step(0, 0, OP_ERET, 32'd0, 32'd0, 0);
         idle(3);
      end

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         step(($urandom_range(0, 79) == 0), ($urandom_range(0, 5) == 0), pick_op(),
              pick_val(), pick_val(), ($urandom_range(0, 9) == 0));
      end

      idle(1);
      @(negedge clock);
      #1;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: got=%0d pending expected=0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
